muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting in the EX stage next to `alu` and fed from the same ID/EX operand registers. It runs MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO in a single cycle. Its architectural HI/LO registers feed the ALU A-operand mux for MFHI/MFLO, and the ALU then passes them through with `ALU_NOP`. The hazard unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  issue strobe, sampled only in IDLE
- `op`  in  3  `MDU_MULT`=0, `MDU_MULTU`=1, `MDU_DIV`=2, `MDU_DIVU`=3, `MDU_MTHI`=4, `MDU_MTLO`=5; values 6–7 are reserved no-ops
- `a`  in  32  rs operand (multiplicand / dividend / MT source)
- `b`  in  32  rt operand (multiplier / divisor)
- `flush`  in  1  abort in-flight operation (exception/branch kill)
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States:
  - IDLE → CALC on `start` with op 0–3.
  - CALC: 32 iterations, 5-bit counter, then → FIXUP.
  - FIXUP → IDLE.
- Operands are latched at accept; `a`/`b` are don't-care afterwards.
- Signed ops convert operands to magnitudes at accept and record the result signs.
- Multiply: radix-2 shift-add on the 64-bit {acc, multiplier} register, unsigned magnitudes. FIXUP negates the 64-bit product if the signs differ.
- Divide: restoring, 33-bit partial remainder, one quotient bit per iteration. FIXUP applies signs:
  - quotient negated if `sign(a) ^ sign(b)`
  - remainder takes `sign(a)`
- DIV/DIVU with `b`=0: no iteration result is used. FIXUP writes HI=`a` (latched, unmodified) and LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude path, so no special case is needed.
- Result mapping: MULT/MULTU give HI=product[63:32], LO=product[31:0]. DIV/DIVU give LO=quotient, HI=remainder.
- MTHI/MTLO with `start` in IDLE: write `a` into HI or LO at that edge. No state change, no `busy`, no `done`.
- `start` while busy is ignored. The hazard unit guarantees no issue while `busy`.
- `flush`:
  - In CALC or FIXUP: → IDLE at the next edge. HI/LO are untouched and `done` is not asserted.
  - In IDLE: suppresses a same-cycle `start`, including MTHI/MTLO.
- `flush` beats the FIXUP write when both occur in the same cycle.
- `hi`/`lo` show the old values throughout an operation.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, counter=0
  - `busy`=0, `done`=0
  - `hi`=0, `lo`=0
  - datapath registers cleared
- Reset mid-operation aborts the operation with the same values.
- `start` accepted at edge N:
  - `busy`=1 from after edge N through edge N+33 (33 cycles: 32 CALC + 1 FIXUP).
  - HI/LO are written and `done`=1 after edge N+33, for one cycle. `busy`=0 in that cycle.
  - The next `start` is accepted at edge N+34 at the earliest, i.e. in the `done` cycle.
- MTHI/MTLO: HI/LO are visible the cycle after the accepting edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Add the `MDU_*` op encodings to `ctrl_encode_def.v` beside the `ALU_*` defines, so the decoder shares them.
- Keep state encodings (`MDU_S_IDLE`, `MDU_S_CALC`, `MDU_S_FIXUP`) local to the module.
- Sub-module `mdu_step`: purely combinational, one iteration that selects between the shift-add step and the restore-subtract step from the current registers. It keeps the FSM file small.
- Expected size: about 200 lines of RTL in total.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → after 34 cycles `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB. `busy` is high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then DIVU a=100, b=0 → HI=0x00000064, LO=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → HI/LO updated one cycle after each. `busy` and `done` stay 0.
- DIV started, `flush` at the 10th busy cycle → `busy`=0 the next cycle, no `done`, HI/LO keep their prior values. A new MULT issued immediately after completes correctly.
- MULT in flight, `rstn` pulsed low at cycle 20 → `hi`/`lo`/`busy`/`done`=0 immediately. A `start` during reset is ignored. The first op after reset completes in 34 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op encodings and helpers shared by the multiply/divide unit
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int MDU_ITERS = 32;

  // MULT/MULTU/DIV/DIVU all have op[2] clear; everything else never enters CALC
  function automatic logic is_calc_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Two's-complement magnitude of a value whose sign has already been decided
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// rtl/muldiv_unit_step.sv - one combinational shift-add or restoring-divide iteration
import muldiv_unit_pkg::*;

module muldiv_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic             fits;
  logic [WIDTH-1:0] rem;

  // Multiply shifts {acc,mq} right after a conditional add; divide shifts left and restores
  always_comb begin
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    shl     = {acc, mq[WIDTH-1]};
    fits    = (shl >= {1'b0, m});
    // when the divisor fits, the true difference is below m, so the low bits are exact
    rem     = shl[WIDTH-1:0] - m;
    acc_nxt = sum[WIDTH:1];
    mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt = fits ? rem : shl[WIDTH-1:0];
      mq_nxt  = {mq[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/DIV unit with architectural HI/LO registers
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    MDU_S_IDLE  = 2'd0,
    MDU_S_CALC  = 2'd1,
    MDU_S_FIXUP = 2'd2
  } mdu_state_e;

  mdu_state_e state, state_nxt;

  logic [4:0]         cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               div0;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               sa, sb;
  logic [WIDTH-1:0]   acc_nxt, mq_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = (state == MDU_S_IDLE) && start && !flush;
  assign busy   = (state != MDU_S_IDLE);

  muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .mq      (mq),
    .m       (m),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // Operand signs for the signed ops (MULT=0, DIV=2 have op[0] clear)
  always_comb begin
    sa = !op[0] && a[WIDTH-1];
    sb = !op[0] && b[WIDTH-1];
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MDU_S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush aborts any in-flight operation
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_S_IDLE:  if (accept && is_calc_op(op)) state_nxt = MDU_S_CALC;
      MDU_S_CALC: begin
        if (flush)                               state_nxt = MDU_S_IDLE;
        else if (cnt == 5'(MDU_ITERS - 1))       state_nxt = MDU_S_FIXUP;
      end
      MDU_S_FIXUP: state_nxt = MDU_S_IDLE;
      default:     state_nxt = MDU_S_IDLE;
    endcase
  end

  // Sign fixup and result mapping; divide-by-zero bypasses the iteration result
  always_comb begin
    prod   = {acc, mq};
    prod   = neg_q ? ((2*WIDTH)'(0) - prod) : prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = mag32(acc, neg_r);
        res_lo = mag32(mq, neg_q);
      end
    end
  end

  // Datapath: operand latch at accept, one iteration per CALC cycle, HI/LO write in FIXUP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      m      <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_S_IDLE: begin
          if (accept) begin
            case (op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                cnt    <= '0;
                acc    <= '0;
                mq     <= mag32(a, sa);
                m      <= mag32(b, sb);
                a_raw  <= a;
                is_div <= op[1];
                div0   <= (b == '0);
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
              end
              MDU_MTHI: hi <= a;
              MDU_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MDU_S_CALC: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          cnt <= cnt + 5'd1;
        end
        MDU_S_FIXUP: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = 64'd0;
    case (o)
      3'd0: p = 64'(sx * sy);
      3'd1: p = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else p = {x % y, x / y};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] expv, input bit poke);
    int n, busy_n;
    logic [63:0] e;
    exp_q.push_back(expv);
    launch(o, x, y);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    busy_n = 1;
    n = 0;
    while (!done && n < 100) begin
      if (poke && n == 5) begin start = 1'b1; op = 3'd4; a = 32'h0BAD0BAD; end
      if (poke && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (n == 16) begin
        check({tag, "_hold_hi"}, hi, mdl_hi);
        check({tag, "_hold_lo"}, lo, mdl_lo);
      end
    end
    start = 1'b0;
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
      check({tag, "_lat"}, 32'(n), 32'd33);
      check({tag, "_busyn"}, 32'(busy_n), 32'd33);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      mdl_hi = e[63:32];
      mdl_lo = e[31:0];
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          bc;

    rstn = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b0);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_op("div_zero", 3'd2, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF, 1'b0);
    run_op("divu_big", 3'd3, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, 1'b1);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_done", 32'(done), 32'd0);
    op = 3'd5; a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);
    mdl_hi = 32'h12345678;
    mdl_lo = 32'h9ABCDEF0;

    // flush in IDLE suppresses both MT and calc starts
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'h55555555;
    @(posedge clk); #1;
    check("iflush_lo", lo, mdl_lo);
    op = 3'd2; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("iflush_busy", 32'(busy), 32'd0);

    // flush on the 10th busy cycle of a DIV
    launch(3'd2, 32'd1000, 32'd7);
    bc = 1;
    while (bc < 10) begin @(posedge clk); #1; bc++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_hi", hi, mdl_hi);
    check("flush_lo", lo, mdl_lo);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) check("flush_late_done", 32'(done), 32'd0);
    end
    run_op("post_flush", 3'd0, 32'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFEC, 1'b0);

    // reset pulsed mid-MULT
    launch(3'd0, 32'h00001234, 32'h00005678);
    repeat (19) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    check("mrst_start_hi", hi, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", 32'(busy), 32'd0);
    run_op("post_rst", 3'd1, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b0);

    // randomized operations against the behavioural model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      if (ry[0] && i > 4) rx = -rx;
      run_op("rand", ro, rx, ry, model(ro, rx, ry), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
